// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: 2-FF input synchronizer, oversampled start/data/stop
// sampling at bit midpoints, glitch rejection, framing-error and break handling.
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_CLK_ENABLE,
    input  logic       i_RX,
    output logic [7:0] o_DATA,
    output logic       o_DATA_VALID,
    output logic       o_FRAME_ERROR
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

    localparam logic [2:0] s_IDLE  = 3'd0;
    localparam logic [2:0] s_START = 3'd1;
    localparam logic [2:0] s_DATA  = 3'd2;
    localparam logic [2:0] s_STOP  = 3'd3;
    localparam logic [2:0] s_BREAK = 3'd4;

    logic          sync1_q;
    logic          rx_s_q;
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    // Synchronizer runs every clock, independent of the oversample tick.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= i_RX;
            rx_s_q  <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (i_CLK_ENABLE) begin
            case (state_q)
                s_IDLE: begin
                    tick_d = '0;
                    if (!rx_s_q) state_d = s_START;
                end
                s_START: begin
                    if (tick_q == HALF_M1) begin
                        tick_d  = '0;
                        bit_d   = 3'd0;
                        state_d = rx_s_q ? s_IDLE : s_DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                s_DATA: begin
                    if (tick_q == FULL_M1) begin
                        tick_d  = '0;
                        shift_d = {rx_s_q, shift_q[7:1]};
                        if (bit_q == 3'd7) state_d = s_STOP;
                        else               bit_d   = bit_q + 3'd1;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                s_STOP: begin
                    if (tick_q == FULL_M1) begin
                        tick_d = '0;
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = s_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = s_BREAK;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                s_BREAK: begin
                    // A line held low after a bad stop bit must not look like a new start.
                    tick_d = '0;
                    if (rx_s_q) state_d = s_IDLE;
                end
                default: begin
                    tick_d  = '0;
                    state_d = s_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= s_IDLE;
            tick_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_DATA        = data_q;
    assign o_DATA_VALID  = valid_q;
    assign o_FRAME_ERROR = ferr_q;

endmodule
